// File: rtl/handshake_pipe.sv
// handshake_pipe: chain of STAGES valid/ready skid stages with occupancy count and flush.
// Optional HANDSHAKE_PIPE_STALL_CNT_EN adds a saturating 16-bit downstream stall counter.
module handshake_pipe #(
    parameter  int DATA_W = 8,
    parameter  int STAGES = 2,
    localparam int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_pre_i,
    input  logic [DATA_W-1:0] data_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    output logic [DATA_W-1:0] data_post_o,
    input  logic              ready_post_i,
    output logic [CNT_W-1:0]  count_o
`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    logic [STAGES-1:0]             m_valid;
    logic [STAGES-1:0]             s_valid;
    logic [STAGES-1:0]             in_valid;
    logic [STAGES-1:0]             out_rdy;
    logic [STAGES-1:0]             in_fire;
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0][DATA_W-1:0] m_data;
    logic [STAGES-1:0][DATA_W-1:0] in_data;

    logic up_fire;
    logic dn_fire;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              mv;
        logic              sv;
        logic [DATA_W-1:0] md;
        logic [DATA_W-1:0] sd;

        if (k == 0) begin : g_first
            assign in_valid[k] = valid_pre_i;
            assign in_data[k]  = data_pre_i;
        end else begin : g_chain
            assign in_valid[k] = m_valid[k-1];
            assign in_data[k]  = m_data[k-1];
        end

        if (k == STAGES-1) begin : g_last
            assign out_rdy[k] = ready_post_i;
        end else begin : g_next
            assign out_rdy[k] = !s_valid[k+1];
        end

        assign in_fire[k] = in_valid[k] && !sv;
        assign adv[k]     = !mv || out_rdy[k];
        assign m_valid[k] = mv;
        assign s_valid[k] = sv;
        assign m_data[k]  = md;

        // main/skid update: advance when main is free or drained, else absorb into skid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mv <= 1'b0;
                sv <= 1'b0;
                md <= '0;
                sd <= '0;
            end else if (flush_i) begin
                mv <= 1'b0;
                sv <= 1'b0;
            end else if (adv[k]) begin
                mv <= sv || in_fire[k];
                sv <= 1'b0;
                if (sv) begin
                    md <= sd;
                end else if (in_fire[k]) begin
                    md <= in_data[k];
                end
            end else if (in_fire[k]) begin
                sv <= 1'b1;
                sd <= in_data[k];
            end
        end
    end

    assign ready_pre_o  = !s_valid[0];
    assign valid_post_o = m_valid[STAGES-1];
    assign data_post_o  = m_data[STAGES-1];

    assign up_fire = valid_pre_i && ready_pre_o;
    assign dn_fire = valid_post_o && ready_post_i;

    // occupancy tracks boundary fires only; internal hand-offs conserve entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else begin
            unique case ({up_fire, dn_fire})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
    // counts cycles the output is held back by downstream, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            stall_cnt_o <= '0;
        end else if (valid_post_o && !ready_post_i
                     && stall_cnt_o != 16'hFFFF) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`else
    // no stall counter in this build
`endif

endmodule

// File: tb/tb_handshake_pipe.sv
// tb_handshake_pipe: directed and random-backpressure checks of handshake_pipe
// against a FIFO-with-per-stage-occupancy model.
module tb_handshake_pipe;

    localparam int DW  = 8;
    localparam int STG = 2;
    localparam int CW  = $clog2(2*STG+1);
    localparam int L   = STG - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_pre_i = 1'b0;
    logic [DW-1:0] data_pre_i = '0;
    logic          ready_pre_o;
    logic          valid_post_o;
    logic [DW-1:0] data_post_o;
    logic          ready_post_i = 1'b0;
    logic [CW-1:0] count_o;
`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    handshake_pipe #(.DATA_W(DW), .STAGES(STG)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .valid_pre_i  (valid_pre_i),
        .data_pre_i   (data_pre_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .ready_post_i (ready_post_i),
        .count_o      (count_o)
`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // model: one FIFO in arrival order, plus how many entries each stage holds
    logic [DW-1:0] pq[$];
    int  sz [STG];
    int  exp_stall = 0;
    bit  mv [STG];
    bit  up_m, dn_m;
    bit  chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pq.delete();
            for (int k = 0; k < STG; k++) sz[k] = 0;
            exp_stall = 0;
        end else begin
            up_m = valid_pre_i && (sz[0] < 2);
            dn_m = (sz[L] > 0) && ready_post_i;
            for (int k = 0; k < L; k++)
                mv[k] = (sz[k] > 0) && (sz[k+1] < 2);
            if (flush_i)
                exp_stall = 0;
            else if (sz[L] > 0 && !ready_post_i && exp_stall < 65535)
                exp_stall++;
            if (dn_m) void'(pq.pop_front());
            if (flush_i) begin
                pq.delete();
                for (int k = 0; k < STG; k++) sz[k] = 0;
            end else begin
                for (int k = 0; k < L; k++) begin
                    if (mv[k]) begin
                        sz[k]--;
                        sz[k+1]++;
                    end
                end
                if (dn_m) sz[L]--;
                if (up_m) begin
                    sz[0]++;
                    pq.push_back(data_pre_i);
                end
            end
        end
        #1;
        if (chk_en && !rst) begin
            chk("m_ready_pre", ready_pre_o, sz[0] < 2);
            chk("m_valid_post", valid_post_o, sz[L] > 0);
            chk("m_count", count_o, pq.size());
            if (sz[L] > 0) chk("m_data_post", data_post_o, pq[0]);
`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
            chk("m_stall_cnt", stall_cnt_o, exp_stall);
`endif
        end
    end

    // downstream monitor: inputs and outputs are both settled at negedge
    logic [DW-1:0] rxq[$];
    int aa_seen = 0;
    always @(negedge clk) begin
        if (!rst && valid_post_o && ready_post_i) begin
            rxq.push_back(data_post_o);
            if (data_post_o == 8'hAA) aa_seen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int acc, sent, bad, guard;
    bit fire;

    initial begin
        // reset without any clock edge
        #1;
        rst = 1'b1;
        valid_pre_i  = 1'($urandom);
        data_pre_i   = 8'($urandom);
        ready_post_i = 1'($urandom);
        flush_i      = 1'($urandom);
        #1;
        chk("rst_ready_pre", ready_pre_o, 1);
        chk("rst_valid_post", valid_post_o, 0);
        chk("rst_data_post", data_post_o, 0);
        chk("rst_count", count_o, 0);
        valid_pre_i = 0;
        data_pre_i = 0;
        ready_post_i = 0;
        flush_i = 0;
        tick;
        tick;
        rst = 1'b0;
        chk_en = 1'b1;

        // streaming 0x01..0x10 at full rate
        ready_post_i = 1;
        rxq.delete();
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) chk("lat_not_yet", valid_post_o, 0);
            if (i == 3) begin
                chk("lat_valid", valid_post_o, 1);
                chk("lat_data", data_post_o, 8'h01);
            end
            if (i == 10) chk("stream_count", count_o, 2);
            chk("stream_ready", ready_pre_o, 1);
            valid_pre_i = 1;
            data_pre_i = 8'(i);
            tick;
        end
        valid_pre_i = 0;
        repeat (4) tick;
        chk("stream_n", rxq.size(), 16);
        bad = 0;
        foreach (rxq[j]) if (rxq[j] != 8'(j + 1)) bad++;
        chk("stream_order", bad, 0);

        // fill against a stalled sink, then drain
        ready_post_i = 0;
        acc = 0;
        for (int g = 0; g < 20; g++) begin
            if (!ready_pre_o) break;
            valid_pre_i = 1;
            data_pre_i = 8'(8'h21 + acc);
            acc++;
            tick;
        end
        valid_pre_i = 0;
        chk("fill_accepted", acc, 4);
        chk("fill_count", count_o, 4);
        chk("fill_ready", ready_pre_o, 0);
        ready_post_i = 1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", valid_post_o, 1);
            chk("drain_data", data_post_o, 8'h21 + j);
            tick;
        end
        chk("drain_empty_valid", valid_post_o, 0);
        chk("drain_empty_count", count_o, 0);

        // random backpressure, 1000 beats, upstream holds until fire
        rxq.delete();
        sent = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            if (!valid_pre_i && $urandom_range(0, 99) < 60) begin
                valid_pre_i = 1;
                data_pre_i = sent[7:0];
            end
            ready_post_i = $urandom_range(0, 99) < 60;
            fire = valid_pre_i && ready_pre_o;
            tick;
            if (fire) begin
                sent++;
                valid_pre_i = 0;
            end
            guard++;
        end
        valid_pre_i = 0;
        chk("rand_sent", sent, 1000);
        ready_post_i = 1;
        guard = 0;
        while (count_o != 0 && guard < 50) begin
            tick;
            guard++;
        end
        tick;
        chk("rand_rx_n", rxq.size(), 1000);
        bad = 0;
        foreach (rxq[j]) if (rxq[j] != 8'(j)) bad++;
        chk("rand_order", bad, 0);

        // flush with a simultaneous upstream fire of 0xAA
        ready_post_i = 0;
        for (int j = 0; j < 3; j++) begin
            chk("fl_push_ready", ready_pre_o, 1);
            valid_pre_i = 1;
            data_pre_i = 8'(8'h31 + j);
            tick;
        end
        valid_pre_i = 0;
        chk("fl_count3", count_o, 3);
        aa_seen = 0;
        chk("fl_aa_ready", ready_pre_o, 1);
        flush_i = 1;
        valid_pre_i = 1;
        data_pre_i = 8'hAA;
        tick;
        flush_i = 0;
        valid_pre_i = 0;
        chk("fl_count", count_o, 0);
        chk("fl_valid", valid_post_o, 0);
        chk("fl_ready", ready_pre_o, 1);
        ready_post_i = 1;
        repeat (4) tick;
        chk("fl_no_aa", aa_seen, 0);
        chk("fl_still_empty", count_o, 0);

`ifdef HANDSHAKE_PIPE_STALL_CNT_EN
        // five stalled cycles with a valid output
        ready_post_i = 0;
        valid_pre_i = 1;
        data_pre_i = 8'h55;
        tick;
        valid_pre_i = 0;
        tick;
        chk("st_zero", stall_cnt_o, 0);
        repeat (5) tick;
        chk("st_five", stall_cnt_o, 5);
        flush_i = 1;
        tick;
        flush_i = 0;
        chk("st_flushed", stall_cnt_o, 0);
`endif

        // asynchronous reset while holding data
        ready_post_i = 0;
        valid_pre_i = 1;
        data_pre_i = 8'h66;
        tick;
        tick;
        valid_pre_i = 0;
        chk("mid_count_before", count_o, 2);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_valid", valid_post_o, 0);
        chk("mid_rst_ready", ready_pre_o, 1);
        chk("mid_rst_data", data_post_o, 0);
        tick;
        rst = 0;
        tick;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
